// File: rtl/alu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional build macro MULDIV_EARLY_OUT_EN retires trivial operations straight from IDLE.
module alu_muldiv #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] LAST_ITER = XLEN'(XLEN - 1);

  state_t state, state_next;

  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_raw_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   count_q;
  logic              a_neg_q, b_neg_q, div0_q, ovf_q;
  logic [XLEN-1:0]   result_q;
  logic [TAG_W-1:0]  tag_q;

  // Divide-by-zero and signed-overflow results, shared by the early-out and FIX paths.
  function automatic logic [XLEN-1:0] special_res(input logic is_rem, input logic div0,
                                                  input logic [XLEN-1:0] a_raw);
    if (div0) return is_rem ? a_raw : '1;
    else      return is_rem ? '0 : a_raw;
  endfunction

  // Operand decode at accept
  logic            accept;
  logic            in_is_div, a_signed, b_signed, a_neg, b_neg, div0_in, ovf_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            early_in;
  logic [XLEN-1:0] early_res;

  assign accept    = (state == IDLE) && in_valid && !flush;
  assign in_is_div = in_op[2];
  assign a_signed  = in_is_div ? !in_op[0] : (in_op[1:0] == 2'b01 || in_op[1:0] == 2'b10);
  assign b_signed  = in_is_div ? !in_op[0] : (in_op[1:0] == 2'b01);
  assign a_neg     = a_signed && in_a[XLEN-1];
  assign b_neg     = b_signed && in_b[XLEN-1];
  assign a_mag     = a_neg ? -in_a : in_a;
  assign b_mag     = b_neg ? -in_b : in_b;
  assign div0_in   = (in_b == '0);
  assign ovf_in    = in_is_div && !in_op[0] && (in_a == MIN_NEG) && (in_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
  assign early_in  = in_is_div ? (div0_in || ovf_in) : (in_a == '0 || in_b == '0);
  assign early_res = in_is_div ? special_res(in_op[1], div0_in, in_a) : '0;
`else
  assign early_in  = 1'b0;
  assign early_res = '0;
`endif

  // One radix-2 iteration of each datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_acc;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc   = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = {rem_q, acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = !div_diff[XLEN];
  assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_acc   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};

  // Sign correction and result select
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  assign prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
  assign quo_fix  = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = a_neg_q ? -rem_q : rem_q;

  always_comb begin
    fix_result = '0;
    if (!op_q[2])
      fix_result = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (div0_q || ovf_q)
      fix_result = special_res(op_q[1], div0_q, a_raw_q);
    else
      fix_result = op_q[1] ? rem_fix : quo_fix;
  end

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) state_next = early_in ? DONE : CALC;
      end
      CALC: if (count_q == LAST_ITER) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignment only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (accept) begin
      count_q <= '0;
      tag_q   <= in_tag;
      if (early_in) result_q <= early_res;
    end else if (state == CALC) begin
      count_q <= count_q + 1'b1;
    end else if (state == FIX) begin
      result_q <= fix_result;
    end
  end

  // NOTE: working registers carry no reset; they are always loaded at accept before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= in_op;
      a_raw_q <= in_a;
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
      div0_q  <= div0_in;
      ovf_q   <= ovf_in;
      rem_q   <= '0;
      opnd_q  <= in_is_div ? b_mag : a_mag;
      acc_q   <= {{XLEN{1'b0}}, (in_is_div ? a_mag : b_mag)};
    end else if (state == CALC) begin
      acc_q <= op_q[2] ? div_acc : mul_acc;
      if (op_q[2]) rem_q <= div_rem;
    end
  end

  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (XLEN=32), honouring MULDIV_EARLY_OUT_EN if defined.
module tb_alu_muldiv;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  localparam int NORM_LAT = 34;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_muldiv #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Offer one operation; returns #1 after the accept edge with inputs scrambled.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
    check("in_ready before accept", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = ~op; in_a = $urandom; in_b = $urandom; in_tag = ~tag;
  endtask

  // Called #1 after the accept edge; waits (bounded) for out_valid and checks the DONE outputs.
  task automatic wait_result(input string name, input logic [31:0] exp, input logic [4:0] tag,
                             input int lat);
    int n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(lat));
    check({name, " result"}, {32'b0, out_result}, {32'b0, exp});
    check({name, " tag"}, {59'b0, out_tag}, {59'b0, tag});
    check({name, " in_ready in DONE"}, {63'b0, in_ready}, 64'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp, input int lat);
    start_op(op, a, b, tag);
    wait_result(name, exp, tag, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " out_valid after handshake"}, {63'b0, out_valid}, 64'd0);
    check({name, " in_ready after handshake"}, {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    bit seen;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset in_ready", {63'b0, in_ready}, 64'd1);
    check("reset out_valid", {63'b0, out_valid}, 64'd0);
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset out_result", {32'b0, out_result}, 64'd0);
    check("reset out_tag", {59'b0, out_tag}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Multiplies
    run_op("MUL 7*-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, NORM_LAT);
    run_op("MULH min*min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, NORM_LAT);
    run_op("MULHU max*max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, NORM_LAT);
    run_op("MULHSU -1*2", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, NORM_LAT);
    run_op("MUL 0*5", OP_MUL, 32'd0, 32'd5, 5'd9, 32'd0, SPEC_LAT);

    // Divides
    run_op("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, NORM_LAT);
    run_op("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, NORM_LAT);
    run_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 5'd12, 32'd14, NORM_LAT);
    run_op("REMU 100/7", OP_REMU, 32'd100, 32'd7, 5'd13, 32'd2, NORM_LAT);

    // Special cases
    run_op("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, SPEC_LAT);
    run_op("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, SPEC_LAT);
    run_op("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, SPEC_LAT);
    run_op("REM 5/0", OP_REM, 32'd5, 32'd0, 5'd17, 32'd5, SPEC_LAT);
    run_op("DIV -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 5'd18, 32'hFFFF_FFFF, SPEC_LAT);

    // Backpressure: result held, next operation offered but refused until after the handshake
    start_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21);
    wait_result("MULHU bp", 32'h0B00_EA4E, 5'd21, NORM_LAT);
    in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd22;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp out_valid held", {63'b0, out_valid}, 64'd1);
      check("bp result held", {32'b0, out_result}, 64'h0B00_EA4E);
      check("bp tag held", {59'b0, out_tag}, 64'd21);
      check("bp in_ready low", {63'b0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp no accept at handshake", {63'b0, busy}, 64'd0);
    check("bp in_ready after handshake", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp accepted next cycle", {63'b0, busy}, 64'd1);
    wait_result("DIVU after bp", 32'd14, 5'd22, NORM_LAT);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Flush at CALC cycle 10, then flush racing an offer in IDLE
    start_op(OP_MUL, 32'd3, 32'd4, 5'd23);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {63'b0, busy}, 64'd0);
    check("flush out_valid", {63'b0, out_valid}, 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_op = OP_DIV; in_a = 32'd8; in_b = 32'd2; in_tag = 5'd24;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush blocks accept", {63'b0, busy}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flushed op never valid", {63'b0, seen}, 64'd0);
    run_op("DIVU 9/3 after flush", OP_DIVU, 32'd9, 32'd3, 5'd3, 32'd3, NORM_LAT);

    // Reset mid-operation
    start_op(OP_MUL, 32'd11, 32'd13, 5'd30);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midop reset busy", {63'b0, busy}, 64'd0);
    check("midop reset in_ready", {63'b0, in_ready}, 64'd1);
    check("midop reset out_result", {32'b0, out_result}, 64'd0);
    check("midop reset out_tag", {59'b0, out_tag}, 64'd0);
    run_op("MUL 11*13 after reset", OP_MUL, 32'd11, 32'd13, 5'd31, 32'd143, NORM_LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
